// File: rtl/quad_decoder_if.sv
// quad_decoder_if: sample/clear control, quadrature phase inputs and position/status outputs of quad_decoder.
interface quad_decoder_if #(
  parameter int POS_W = 8
);
  logic             ce;
  logic             clr;
  logic             steer_a;
  logic             steer_b;
  logic [POS_W-1:0] pos;
  logic             step;
  logic             dir;
  logic             err;

  modport master (output ce, clr, steer_a, steer_b, input pos, step, dir, err);
  modport slave  (input ce, clr, steer_a, steer_b, output pos, step, dir, err);
endinterface

// File: rtl/quad_decoder.sv
// quad_decoder: synchronized quadrature decoder; with ce high an input edge reaches pos/step 3 CLK after first capture.
// Define QUADDEC_FILTER_EN to add a FILT_LEN-sample per-phase glitch filter (adds FILT_LEN-1 ce samples of latency).
module quad_decoder #(
  parameter int POS_W    = 8,
  parameter int WRAP     = 1,
  parameter int FILT_LEN = 4
) (
  input logic           CLK,
  input logic           reset,
  quad_decoder_if.slave qd
);

  if (POS_W < 4 || POS_W > 16 || FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_cfg
    $error("quad_decoder: parameter out of range");
  end

  logic [1:0]       sync1, sync2, sync_vld;
  logic [1:0]       cur, prev, chg;
  logic             cur_vld, init, sample, up;
  logic             count_en, err_en;
  logic [POS_W-1:0] pos_q, pos_nxt;
  logic             step_q, dir_q, err_q;

  // sync_vld tracks how far real input has propagated since reset, so stale reset values are never decoded.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= '0;
    end else begin
      sync1    <= {qd.steer_a, qd.steer_b};
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

`ifdef QUADDEC_FILTER_EN
  logic [1:0][3:0] cnt;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cur     <= '0;
      cur_vld <= 1'b0;
      cnt     <= '0;
    end else if (qd.ce && sync_vld[1]) begin
      if (!cur_vld) begin
        cur     <= sync2;
        cur_vld <= 1'b1;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (sync2[i] == cur[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == 4'(FILT_LEN - 1)) begin
            cur[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end
      end
    end
  end
`else
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cur     <= '0;
      cur_vld <= 1'b0;
    end else begin
      cur     <= sync2;
      cur_vld <= sync_vld[1];
    end
  end
`endif

  assign sample = qd.ce && cur_vld;
  assign chg    = cur ^ prev;
  // Gray order 00,10,11,01: a move is "up" exactly when old A equals new B.
  assign up     = (prev[1] == cur[0]);

  always_comb begin
    count_en = 1'b0;
    err_en   = 1'b0;
    pos_nxt  = pos_q;
    if (sample && !init) begin
      if (chg == 2'b11)      err_en   = 1'b1;
      else if (chg != 2'b00) count_en = 1'b1;
    end
    if (count_en) begin
      if (up) begin
        if (WRAP != 0 || pos_q != '1) pos_nxt = pos_q + POS_W'(1);
      end else begin
        if (WRAP != 0 || pos_q != '0) pos_nxt = pos_q - POS_W'(1);
      end
    end
    if (qd.clr) pos_nxt = '0;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pos_q  <= '0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
      dir_q  <= 1'b0;
      prev   <= '0;
      init   <= 1'b1;
    end else begin
      pos_q  <= pos_nxt;
      step_q <= count_en;
      err_q  <= err_en;
      if (count_en) dir_q <= up;
      if (sample) begin
        prev <= cur;
        init <= 1'b0;
      end
    end
  end

  assign qd.pos  = pos_q;
  assign qd.step = step_q;
  assign qd.dir  = dir_q;
  assign qd.err  = err_q;

endmodule
